// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, special constants and the packed float view.
package fp16_pkg;

    localparam int unsigned EXP_WIDTH = 5;
    localparam int unsigned MAN_WIDTH = 10;
    localparam int unsigned EXP_BIAS  = 15;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/fp16_lzc.sv
// 15-bit leading-zero counter; an all-zero input reports 15.
module fp16_lzc (
    input  logic [14:0] data_i,
    output logic [3:0]  count_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count_o = 4'd15;
        for (int i = 0; i < 15; i++) begin
            if (data_i[i]) begin
                count_o = 4'(14 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_add_unit.sv
// Single-cycle binary16 adder: combinational datapath into one output register.
// Define FP16_ADD_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp16_add_unit
    import fp16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_a_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_a_tdata,
    input  logic                  s_axis_b_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
    output logic                  m_axis_result_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_result_tdata
);

    fp16_t op_a, op_b;
    assign op_a = fp16_t'(s_axis_a_tdata);
    assign op_b = fp16_t'(s_axis_b_tdata);

    logic              nan_a, nan_b, inf_a, inf_b;
    logic [4:0]        exp_a, exp_b, exp_l, exp_s, diff_raw, diff;
    logic [10:0]       sig_a, sig_b, sig_l, sig_s;
    logic              sign_l, sign_s, swap;
    logic [27:0]       align_ext;
    logic [13:0]       large_al, small_al;
    logic [14:0]       sum, norm;
    logic [3:0]        lz, shift;
    logic signed [6:0] exp_norm, exp_final;
    logic              round_up;
    logic [11:0]       mant;
    logic [15:0]       result;

    assign nan_a = (op_a.exp == 5'd31) && (op_a.frac != '0);
    assign nan_b = (op_b.exp == 5'd31) && (op_b.frac != '0);
    assign inf_a = (op_a.exp == 5'd31) && (op_a.frac == '0);
    assign inf_b = (op_b.exp == 5'd31) && (op_b.frac == '0);

    always_comb begin
`ifdef FP16_ADD_SUBNORMAL_EN
        exp_a = (op_a.exp == '0) ? 5'd1 : op_a.exp;
        exp_b = (op_b.exp == '0) ? 5'd1 : op_b.exp;
        sig_a = {op_a.exp != '0, op_a.frac};
        sig_b = {op_b.exp != '0, op_b.frac};
`else
        exp_a = op_a.exp;
        exp_b = op_b.exp;
        sig_a = (op_a.exp == '0) ? 11'd0 : {1'b1, op_a.frac};
        sig_b = (op_b.exp == '0) ? 11'd0 : {1'b1, op_b.frac};
`endif
        swap   = {exp_b, sig_b} > {exp_a, sig_a};
        exp_l  = swap ? exp_b : exp_a;
        exp_s  = swap ? exp_a : exp_b;
        sig_l  = swap ? sig_b : sig_a;
        sig_s  = swap ? sig_a : sig_b;
        sign_l = swap ? op_b.sign : op_a.sign;
        sign_s = swap ? op_a.sign : op_b.sign;

        diff_raw  = exp_l - exp_s;
        diff      = (diff_raw > 5'd14) ? 5'd14 : diff_raw;
        // Low 14 bits of the extended value are everything shifted past the round bit.
        align_ext = {sig_s, 3'b000, 14'd0} >> diff;
        small_al  = {align_ext[27:15], align_ext[14] | (|align_ext[13:0])};
        large_al  = {sig_l, 3'b000};

        sum = (sign_l ^ sign_s) ? ({1'b0, large_al} - {1'b0, small_al})
                                : ({1'b0, large_al} + {1'b0, small_al});
    end

    fp16_lzc u_lzc (
        .data_i  (sum),
        .count_o (lz)
    );

    always_comb begin
`ifdef FP16_ADD_SUBNORMAL_EN
        // Stop normalising at exponent 1 so tiny results land as subnormals.
        shift = ({1'b0, lz} > exp_l) ? exp_l[3:0] : lz;
`else
        shift = lz;
`endif
        norm     = sum << shift;
        exp_norm = $signed({2'b00, exp_l}) + 7'sd1 - $signed({3'b000, shift});
        round_up = norm[3] & ((|norm[2:0]) | norm[4]);
        mant     = {1'b0, norm[14:4]} + {11'd0, round_up};
        // Bit 10 clear means the value stayed subnormal; bit 11 is a rounding carry.
        exp_final = mant[11] ? (exp_norm + 7'sd1) : (mant[10] ? exp_norm : 7'sd0);

        if (nan_a || nan_b) begin
            result = FP16_QNAN;
        end else if (inf_a && inf_b && (op_a.sign != op_b.sign)) begin
            result = FP16_QNAN;
        end else if (inf_a) begin
            result = s_axis_a_tdata;
        end else if (inf_b) begin
            result = s_axis_b_tdata;
        end else if (sum == '0) begin
            result = {op_a.sign & op_b.sign, 15'd0};
        end else if (exp_final >= 7'sd31) begin
            result = sign_l ? FP16_NINF : FP16_PINF;
`ifndef FP16_ADD_SUBNORMAL_EN
        end else if (exp_final <= 7'sd0) begin
            result = {sign_l, 15'd0};
`endif
        end else begin
            result = {sign_l, exp_final[4:0], mant[9:0]};
        end
    end

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = s_axis_a_tvalid & s_axis_b_tvalid;
        data_d  = valid_d ? result : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_axis_result_tvalid = valid_q;
    assign m_axis_result_tdata  = data_q;

endmodule

// File: tb/tb_fp16_add_unit.sv
// Scoreboard bench for fp16_add_unit; expectations follow FP16_ADD_SUBNORMAL_EN when defined.
module tb_fp16_add_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        r_valid;
    logic [15:0] r_data;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    fp16_add_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tdata       (a_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tdata       (b_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tdata  (r_data)
    );

    task automatic drive(input logic va, input logic vb, input logic [15:0] a,
                         input logic [15:0] b);
        a_valid = va;
        b_valid = vb;
        a_data  = a;
        b_data  = b;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0 || r_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_hold valid=%b data=%h required valid=0 data=0000", r_valid, r_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release valid=%b required 0", r_valid);
        end
    endtask

    // Each entry: {a, b, expected}.
    task automatic test_basic();
        logic [47:0] vec [6];
        logic [15:0] exp_v;
        vec = '{48'h3C00_3C00_4000, 48'h3C00_BC00_0000, 48'hBC00_BC00_C000,
                48'h8000_8000_8000, 48'h3C00_0C00_3C00, 48'h3C01_1000_3C02};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, vec[i][47:32], vec[i][31:16]);
            sb.push_back(vec[i][15:0]);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 16'h0, 16'h0);
            exp_v = sb.pop_front();
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_v) begin
                failures++;
                $display("FAIL basic[%0d] valid=%b data=%h required valid=1 data=%h",
                         i, r_valid, r_data, exp_v);
            end
            @(posedge clk); #1;
            checks++;
            if (r_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_pulse[%0d] valid=%b required 0", i, r_valid);
            end
        end
    endtask

    task automatic test_specials();
        logic [47:0] vec [6];
        logic [15:0] exp_v;
        vec = '{48'h3C00_1400_3C01, 48'h7BFF_7BFF_7C00, 48'h7C00_FC00_7E00,
                48'h7C01_3C00_7E00, 48'hFC00_4000_FC00, 48'hFBFF_FBFF_FC00};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, vec[i][47:32], vec[i][31:16]);
            sb.push_back(vec[i][15:0]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_v) begin
                failures++;
                $display("FAIL special[%0d] valid=%b data=%h required valid=1 data=%h",
                         i, r_valid, r_data, exp_v);
            end
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_subnormal();
        logic [47:0] vec [3];
        logic [15:0] exp_v;
`ifdef FP16_ADD_SUBNORMAL_EN
        vec = '{48'h0001_0001_0002, 48'h0400_8001_03FF, 48'h8001_8001_8002};
`else
        vec = '{48'h0001_0001_0000, 48'h0400_8001_0400, 48'h8001_8001_8000};
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, vec[i][47:32], vec[i][31:16]);
            sb.push_back(vec[i][15:0]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_v) begin
                failures++;
                $display("FAIL subnormal[%0d] valid=%b data=%h required valid=1 data=%h",
                         i, r_valid, r_data, exp_v);
            end
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_lone_valid();
        drive(1'b1, 1'b0, 16'h3C00, 16'h3C00);
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL lone_a valid=%b required 0", r_valid);
        end
        drive(1'b0, 1'b1, 16'h3C00, 16'h3C00);
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL lone_b valid=%b required 0", r_valid);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [47:0] vec [8];
        logic [15:0] exp_v;
        vec = '{48'h3C00_3C00_4000, 48'h4000_3C00_4200, 48'h4200_C000_3C00,
                48'h3800_3800_3C00, 48'h4400_BC00_4200, 48'h5640_5640_5A40,
                48'h3C00_BC00_0000, 48'h3555_0000_3555};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, vec[i][47:32], vec[i][31:16]);
            sb.push_back(vec[i][15:0]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_v) begin
                failures++;
                $display("FAIL stream[%0d] valid=%b data=%h required valid=1 data=%h",
                         i, r_valid, r_data, exp_v);
            end
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end valid=%b required 0", r_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b1, 1'b1, 16'h3C00, 16'h3C00);
        sb.push_back(16'h4000);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'h4000, 16'h4000);
        sb.push_back(16'h4400);
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (r_valid !== 1'b0 || r_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_async valid=%b data=%h required valid=0 data=0000", r_valid, r_data);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0 || r_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_after valid=%b data=%h required valid=0 data=0000", r_valid, r_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_subnormal();
        test_lone_valid();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
